cq_descarte_param: RTL and testbench
====================================

Name: cq_descarte_param

Overview:
- Parametrised successor to the quality-control/discard FSM.
- Driven by the line master via cmd_verificar.
- On command: waits for the CQ position sensor, takes the approve/reject decision (manual confirmation or automatic mode), and times the discard actuator.
- Adds sensor timeout, consecutive-reject lockout, saturating approved/rejected counters, and a completion handshake for both outcomes.

Parameters:
- TEMPO_DESCARTE, 25000000, discard actuator on-time in clk cycles (0.5 s at 50 MHz); legal range ≥1.
- TIMEOUT_SENSOR, 250000000, max cycles in VERIFICANDO waiting for sensor_cq before alarm; legal range ≥1.
- MAX_REJ_CONSEC, 3, consecutive rejects that trigger lockout; legal range 1..255.
- CONT_W, 8, width of approved/rejected counters.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- cmd_verificar  in  1  master command, level; held until tarefa_concluida seen
- sensor_cq  in  1  bottle at CQ position (SW2)
- pulso_start  in  1  one-cycle operator confirm/ack (debounced KEY[0])
- resultado_cq  in  1  0=reprovado, 1=aprovado (SW3)
- modo_auto  in  1  1=decide on sensor edge without operator; sampled in VERIFICANDO
- descarte_ativo  out  1  discard actuator (LEDR[6])
- garrafa_aprovada  out  1  one-cycle pulse per approved bottle (dozen counter)
- tarefa_concluida  out  1  level, outcome done, held until cmd_verificar low
- alarme  out  1  level, block locked in ALARME
- codigo_alarme  out  2  0=none, 1=sensor timeout, 2=reject lockout
- cnt_aprovadas  out  CONT_W  saturating approved count
- cnt_reprovadas  out  CONT_W  saturating rejected count

Behaviour:
- Reset (async): state IDLE, timer 0, rej_consec 0, all outputs 0.
- States: IDLE, VERIFICANDO, AGUARDA_DECISAO, DESCARTANDO, CONCLUIDO, ALARME.
- Outputs are Moore, registered from the current state. They change exactly one clk after the state register changes, same timing as the existing CQ FSM.
- garrafa_aprovada and the counter increments are registered pulses issued on the approval transition.
- IDLE: timer=0. cmd_verificar=1 -> VERIFICANDO.
- VERIFICANDO: timer increments each cycle.
  - sensor_cq=1: timer=0. If modo_auto=0 -> AGUARDA_DECISAO. If modo_auto=1 -> decide on resultado_cq that cycle, as in AGUARDA_DECISAO.
  - sensor_cq=0 and timer==TIMEOUT_SENSOR-1 -> ALARME, codigo 1.
  - sensor_cq wins over timeout in the same cycle.
  - cmd_verificar=0 (abort) -> IDLE; no counter change. Abort has priority over everything in this state.
- AGUARDA_DECISAO: no timeout.
  - pulso_start=1 and resultado_cq=0 -> DESCARTANDO.
  - pulso_start=1 and resultado_cq=1 -> CONCLUIDO: one-cycle garrafa_aprovada, cnt_aprovadas+1 (saturating), rej_consec=0.
  - cmd_verificar=0 -> IDLE (abort, priority over pulso_start).
- DESCARTANDO: descarte_ativo=1; timer increments. cmd_verificar is ignored; the discard always completes.
  - At timer==TEMPO_DESCARTE-1: timer=0, cnt_reprovadas+1 (saturating), rej_consec+1.
  - If new rej_consec==MAX_REJ_CONSEC -> ALARME, codigo 2; else -> CONCLUIDO.
  - descarte_ativo is high for exactly TEMPO_DESCARTE cycles.
- CONCLUIDO: tarefa_concluida=1. cmd_verificar=0 -> IDLE.
- ALARME: alarme=1, codigo held, descarte_ativo=0, tarefa_concluida=0.
  - pulso_start=1 -> IDLE: rej_consec=0, codigo cleared.
  - cmd_verificar is ignored. The master must observe alarme and drop the command.
  - If cmd_verificar is still high on return to IDLE, a new cycle starts immediately (same rule as IDLE).
- Counters: saturate at 2^CONT_W-1 and never wrap. Only reset clears them.
- rej_consec: 8 bits, internal.
- pulso_start outside AGUARDA_DECISAO/ALARME is ignored.
- Illegal state -> IDLE, timer 0, outputs 0.
- Reset mid-operation (e.g. during discard) drops descarte_ativo asynchronously and clears counters.

Decomposition:
- Package cq_pkg holds:
  - state encodings (3-bit localparams)
  - alarm codes ALM_NENHUM=0, ALM_TIMEOUT=1, ALM_REJ=2
- Sub-module cq_temporizador: width-parametrised up-counter with clear/enable and a terminal-count compare.
  - One instance, shared between timeout and discard timing; the width is derived from max(TEMPO_DESCARTE, TIMEOUT_SENSOR) with $clog2.
- FSM and counters stay in cq_descarte_param.

Test Plan (TEMPO_DESCARTE=4, TIMEOUT_SENSOR=10, MAX_REJ_CONSEC=2, CONT_W=2):
1. Manual approve: cmd=1, sensor=1, pulso_start with resultado=1 -> garrafa_aprovada high 1 cycle, tarefa_concluida=1 until cmd=0, cnt_aprovadas=1.
2. Manual reject: same flow with resultado=0 -> descarte_ativo high exactly 4 cycles, then tarefa_concluida=1, cnt_reprovadas=1, alarme=0.
3. Lockout: two consecutive rejects -> after the second discard, alarme=1, codigo_alarme=2, tarefa_concluida=0. pulso_start -> IDLE, alarme=0. A third reject afterwards does not alarm.
4. Timeout: cmd=1, sensor held 0 -> ALARME codigo 1 after 10 cycles in VERIFICANDO. With sensor=1 on cycle 10 itself, no alarm and normal flow.
5. Auto mode: modo_auto=1, resultado=1, sensor pulse -> approve with no pulso_start. Four approves saturate cnt_aprovadas at 3. A reject in between resets rej_consec.
6. Abort/reset: cmd drops in AGUARDA_DECISAO -> IDLE, counters unchanged. Reset asserted mid-discard -> descarte_ativo=0 immediately, all counters 0.

Source files
------------

// File: rtl/cq_pkg.sv
// Shared encodings for the CQ discard controller: FSM states and alarm codes.
package cq_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_VERIFICANDO = 3'd1;
  localparam logic [2:0] ST_AGUARDA     = 3'd2;
  localparam logic [2:0] ST_DESCARTANDO = 3'd3;
  localparam logic [2:0] ST_CONCLUIDO   = 3'd4;
  localparam logic [2:0] ST_ALARME      = 3'd5;

  typedef enum logic [2:0] {
    IDLE            = ST_IDLE,
    VERIFICANDO     = ST_VERIFICANDO,
    AGUARDA_DECISAO = ST_AGUARDA,
    DESCARTANDO     = ST_DESCARTANDO,
    CONCLUIDO       = ST_CONCLUIDO,
    ALARME          = ST_ALARME
  } estado_t;

  localparam logic [1:0] ALM_NENHUM  = 2'd0;
  localparam logic [1:0] ALM_TIMEOUT = 2'd1;
  localparam logic [1:0] ALM_REJ     = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cq_temporizador.sv
// Up-counter with synchronous clear/enable and a terminal-count compare
// against a runtime-selectable limit.
module cq_temporizador #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limite,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign tc = (count_q == limite);

endmodule

// File: rtl/cq_descarte_param.sv
// Quality-control / discard sequencer: waits for the CQ sensor, takes the
// approve/reject decision, times the discard actuator and locks out on repeated rejects.
//
// state           | meaning
// IDLE            | waiting for cmd_verificar
// VERIFICANDO     | waiting for sensor_cq, timeout armed
// AGUARDA_DECISAO | bottle in place, waiting for operator pulso_start
// DESCARTANDO     | discard actuator on for TEMPO_DESCARTE cycles
// CONCLUIDO       | outcome done, held until cmd_verificar drops
// ALARME          | locked (sensor timeout or reject lockout), cleared by pulso_start
module cq_descarte_param
  import cq_pkg::*;
#(
  parameter int TEMPO_DESCARTE = 25000000,
  parameter int TIMEOUT_SENSOR = 250000000,
  parameter int MAX_REJ_CONSEC = 3,
  parameter int CONT_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_verificar,
  input  logic              sensor_cq,
  input  logic              pulso_start,
  input  logic              resultado_cq,
  input  logic              modo_auto,
  output logic              descarte_ativo,
  output logic              garrafa_aprovada,
  output logic              tarefa_concluida,
  output logic              alarme,
  output logic [1:0]        codigo_alarme,
  output logic [CONT_W-1:0] cnt_aprovadas,
  output logic [CONT_W-1:0] cnt_reprovadas
);

  localparam int TMAX = max_int(TEMPO_DESCARTE, TIMEOUT_SENSOR);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]     LIM_DESC = TW'(TEMPO_DESCARTE - 1);
  localparam logic [TW-1:0]     LIM_SENS = TW'(TIMEOUT_SENSOR - 1);
  localparam logic [7:0]        REJ_MAX  = 8'(MAX_REJ_CONSEC);
  localparam logic [CONT_W-1:0] CNT_SAT  = '1;

  function automatic logic [CONT_W-1:0] sat_inc(input logic [CONT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  estado_t           state_q, state_d;
  logic [7:0]        rej_q, rej_d, rej_inc;
  logic [1:0]        alm_q, alm_d;
  logic [CONT_W-1:0] cnt_ap_q, cnt_ap_d, cnt_rej_q, cnt_rej_d;
  logic              desc_q, desc_d, tarefa_q, tarefa_d, alarme_q, alarme_d;
  logic              garrafa_q, garrafa_d;
  logic [1:0]        codigo_q, codigo_d;
  logic              tmr_clr, tmr_en, tmr_tc, decidir;
  logic [TW-1:0]     tmr_lim;

  cq_temporizador #(.W(TW)) u_tmr (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .limite (tmr_lim),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    rej_d     = rej_q;
    alm_d     = alm_q;
    cnt_ap_d  = cnt_ap_q;
    cnt_rej_d = cnt_rej_q;
    garrafa_d = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    tmr_lim   = LIM_SENS;
    decidir   = 1'b0;
    rej_inc   = rej_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (cmd_verificar) state_d = VERIFICANDO;
      end
      VERIFICANDO: begin
        tmr_en = 1'b1;
        // Abort beats sensor, sensor beats timeout.
        if (!cmd_verificar) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else if (sensor_cq) begin
          tmr_clr = 1'b1;
          if (modo_auto) decidir = 1'b1;
          else           state_d = AGUARDA_DECISAO;
        end else if (tmr_tc) begin
          tmr_clr = 1'b1;
          state_d = ALARME;
          alm_d   = ALM_TIMEOUT;
        end
      end
      AGUARDA_DECISAO: begin
        tmr_clr = 1'b1;
        if (!cmd_verificar)   state_d = IDLE;
        else if (pulso_start) decidir = 1'b1;
      end
      DESCARTANDO: begin
        tmr_lim = LIM_DESC;
        tmr_en  = 1'b1;
        if (tmr_tc) begin
          tmr_clr   = 1'b1;
          cnt_rej_d = sat_inc(cnt_rej_q);
          rej_d     = rej_inc;
          if (rej_inc == REJ_MAX) begin
            state_d = ALARME;
            alm_d   = ALM_REJ;
          end else begin
            state_d = CONCLUIDO;
          end
        end
      end
      CONCLUIDO: begin
        tmr_clr = 1'b1;
        if (!cmd_verificar) state_d = IDLE;
      end
      ALARME: begin
        tmr_clr = 1'b1;
        if (pulso_start) begin
          state_d = IDLE;
          rej_d   = 8'd0;
          alm_d   = ALM_NENHUM;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_clr = 1'b1;
        alm_d   = ALM_NENHUM;
      end
    endcase

    // Shared approve/reject decision for manual confirm and auto mode.
    if (decidir) begin
      if (resultado_cq) begin
        state_d   = CONCLUIDO;
        garrafa_d = 1'b1;
        cnt_ap_d  = sat_inc(cnt_ap_q);
        rej_d     = 8'd0;
      end else begin
        state_d = DESCARTANDO;
      end
    end

    desc_d   = (state_q == DESCARTANDO);
    tarefa_d = (state_q == CONCLUIDO);
    alarme_d = (state_q == ALARME);
    codigo_d = (state_q == ALARME) ? alm_q : ALM_NENHUM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rej_q     <= 8'd0;
      alm_q     <= ALM_NENHUM;
      cnt_ap_q  <= '0;
      cnt_rej_q <= '0;
      desc_q    <= 1'b0;
      tarefa_q  <= 1'b0;
      alarme_q  <= 1'b0;
      codigo_q  <= ALM_NENHUM;
      garrafa_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rej_q     <= rej_d;
      alm_q     <= alm_d;
      cnt_ap_q  <= cnt_ap_d;
      cnt_rej_q <= cnt_rej_d;
      desc_q    <= desc_d;
      tarefa_q  <= tarefa_d;
      alarme_q  <= alarme_d;
      codigo_q  <= codigo_d;
      garrafa_q <= garrafa_d;
    end
  end

  assign descarte_ativo   = desc_q;
  assign garrafa_aprovada = garrafa_q;
  assign tarefa_concluida = tarefa_q;
  assign alarme           = alarme_q;
  assign codigo_alarme    = codigo_q;
  assign cnt_aprovadas    = cnt_ap_q;
  assign cnt_reprovadas   = cnt_rej_q;

endmodule

// File: tb/tb_cq_descarte_param.sv
// Directed bench for cq_descarte_param with an outcome scoreboard
// (TEMPO_DESCARTE=4, TIMEOUT_SENSOR=10, MAX_REJ_CONSEC=2, CONT_W=2).
module tb_cq_descarte_param;

  localparam int TD   = 4;
  localparam int TO   = 10;
  localparam int MAXR = 2;
  localparam int CW   = 2;
  localparam int SAT  = (1 << CW) - 1;

  localparam int K_APROV = 0;
  localparam int K_REJ   = 1;
  localparam int K_LOCK  = 2;
  localparam int K_TOUT  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_verificar = 1'b0, sensor_cq = 1'b0, pulso_start = 1'b0;
  logic          resultado_cq = 1'b0, modo_auto = 1'b0;
  logic          descarte_ativo, garrafa_aprovada, tarefa_concluida, alarme;
  logic [1:0]    codigo_alarme;
  logic [CW-1:0] cnt_aprovadas, cnt_reprovadas;

  cq_descarte_param #(
    .TEMPO_DESCARTE (TD),
    .TIMEOUT_SENSOR (TO),
    .MAX_REJ_CONSEC (MAXR),
    .CONT_W         (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_verificar    (cmd_verificar),
    .sensor_cq        (sensor_cq),
    .pulso_start      (pulso_start),
    .resultado_cq     (resultado_cq),
    .modo_auto        (modo_auto),
    .descarte_ativo   (descarte_ativo),
    .garrafa_aprovada (garrafa_aprovada),
    .tarefa_concluida (tarefa_concluida),
    .alarme           (alarme),
    .codigo_alarme    (codigo_alarme),
    .cnt_aprovadas    (cnt_aprovadas),
    .cnt_reprovadas   (cnt_reprovadas)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int ap;
    int rej;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   m_ap = 0, m_rej = 0, m_rejc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return tarefa_concluida;
      1:       return alarme;
      2:       return descarte_ativo;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_hi(input int sel, input int maxc, input string tag);
    int n = 0;
    while (!sig(sel) && n < maxc) begin
      tick();
      n++;
    end
    check(tag, 32'(sig(sel)), 32'd1);
  endtask

  // Model: predict the outcome and push it before the stimulus is applied.
  task automatic expect_approve();
    exp_t e;
    if (m_ap < SAT) m_ap++;
    m_rejc = 0;
    e.kind = K_APROV; e.ap = m_ap; e.rej = m_rej;
    sb.push_back(e);
  endtask

  task automatic expect_reject();
    exp_t e;
    if (m_rej < SAT) m_rej++;
    m_rejc++;
    e.kind = (m_rejc == MAXR) ? K_LOCK : K_REJ;
    e.ap = m_ap; e.rej = m_rej;
    sb.push_back(e);
  endtask

  task automatic expect_timeout();
    exp_t e;
    e.kind = K_TOUT; e.ap = m_ap; e.rej = m_rej;
    sb.push_back(e);
  endtask

  task automatic outcome(input int kind_obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_outcome", 32'(kind_obs), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      check("sb_kind", 32'(kind_obs), 32'(e.kind));
      check("sb_cnt_aprovadas", 32'(cnt_aprovadas), 32'(e.ap));
      check("sb_cnt_reprovadas", 32'(cnt_reprovadas), 32'(e.rej));
    end
  endtask

  // Outcome monitor: a rise of tarefa_concluida or alarme completes one transaction.
  initial begin
    logic prev_t, prev_a, saw_desc;
    prev_t = 1'b0; prev_a = 1'b0; saw_desc = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_t = 1'b0; prev_a = 1'b0; saw_desc = 1'b0;
      end else begin
        if (descarte_ativo) saw_desc = 1'b1;
        if (tarefa_concluida && !prev_t) begin
          outcome(saw_desc ? K_REJ : K_APROV);
          saw_desc = 1'b0;
        end
        if (alarme && !prev_a) begin
          outcome(codigo_alarme == 2'd2 ? K_LOCK : (codigo_alarme == 2'd1 ? K_TOUT : 9));
          saw_desc = 1'b0;
        end
        prev_t = tarefa_concluida;
        prev_a = alarme;
      end
    end
  end

  task automatic start_manual();
    cmd_verificar = 1'b1;
    sensor_cq = 1'b1;
    tick();
    tick();
    sensor_cq = 1'b0;
  endtask

  task automatic decide(input logic res);
    pulso_start = 1'b1;
    resultado_cq = res;
    tick();
    pulso_start = 1'b0;
  endtask

  task automatic auto_run(input logic res);
    cmd_verificar = 1'b1;
    tick();
    sensor_cq = 1'b1;
    resultado_cq = res;
    tick();
    sensor_cq = 1'b0;
  endtask

  task automatic measure_discard(input string tag);
    int n = 0;
    wait_hi(2, 6, {tag, "_desc_start"});
    while (descarte_ativo && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_desc_len"}, 32'(n), 32'(TD));
  endtask

  task automatic finish_ok(input string tag);
    wait_hi(0, 10, {tag, "_tarefa"});
    check({tag, "_no_alarme"}, 32'(alarme), 32'd0);
    cmd_verificar = 1'b0;
    tick();
    tick();
    check({tag, "_tarefa_drop"}, 32'(tarefa_concluida), 32'd0);
  endtask

  task automatic clear_alarm(input string tag);
    cmd_verificar = 1'b0;
    pulso_start = 1'b1;
    tick();
    pulso_start = 1'b0;
    tick();
    m_rejc = 0;
    check({tag, "_alarme_clr"}, 32'(alarme), 32'd0);
    check({tag, "_codigo_clr"}, 32'(codigo_alarme), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_descarte", 32'(descarte_ativo), 32'd0);
    check("rst_tarefa", 32'(tarefa_concluida), 32'd0);
    check("rst_alarme", 32'(alarme), 32'd0);
    check("rst_cnt_ap", 32'(cnt_aprovadas), 32'd0);
    reset = 1'b0;
    tick();

    // Manual approve
    start_manual();
    expect_approve();
    decide(1'b1);
    check("apr_garrafa_on", 32'(garrafa_aprovada), 32'd1);
    check("apr_tarefa_lag", 32'(tarefa_concluida), 32'd0);
    tick();
    check("apr_garrafa_off", 32'(garrafa_aprovada), 32'd0);
    check("apr_tarefa", 32'(tarefa_concluida), 32'd1);
    check("apr_cnt", 32'(cnt_aprovadas), 32'd1);
    tick();
    tick();
    check("apr_tarefa_held", 32'(tarefa_concluida), 32'd1);
    finish_ok("apr");

    // Manual reject
    start_manual();
    expect_reject();
    decide(1'b0);
    measure_discard("rej1");
    finish_ok("rej1");
    check("rej1_cnt", 32'(cnt_reprovadas), 32'd1);

    // Second consecutive reject -> lockout
    start_manual();
    expect_reject();
    decide(1'b0);
    measure_discard("rej2");
    wait_hi(1, 10, "lock_alarme");
    check("lock_codigo", 32'(codigo_alarme), 32'd2);
    check("lock_tarefa", 32'(tarefa_concluida), 32'd0);
    check("lock_cnt", 32'(cnt_reprovadas), 32'd2);
    repeat (3) tick();
    check("lock_held_cmd_high", 32'(alarme), 32'd1);
    clear_alarm("lock");

    // Third reject after clearing does not alarm; rejected count saturates at 3
    start_manual();
    expect_reject();
    decide(1'b0);
    measure_discard("rej3");
    finish_ok("rej3");
    check("rej3_cnt", 32'(cnt_reprovadas), 32'd3);

    // Sensor timeout
    cmd_verificar = 1'b1;
    sensor_cq = 1'b0;
    expect_timeout();
    repeat (11) tick();
    check("tout_not_yet", 32'(alarme), 32'd0);
    tick();
    check("tout_alarme", 32'(alarme), 32'd1);
    check("tout_codigo", 32'(codigo_alarme), 32'd1);
    clear_alarm("tout");

    // Sensor arriving in the last allowed cycle wins over timeout
    cmd_verificar = 1'b1;
    repeat (10) tick();
    sensor_cq = 1'b1;
    tick();
    sensor_cq = 1'b0;
    tick();
    check("tout_edge_no_alarm", 32'(alarme), 32'd0);
    expect_approve();
    decide(1'b1);
    finish_ok("tout_edge");

    // Auto mode
    modo_auto = 1'b1;
    expect_approve();
    auto_run(1'b1);
    check("auto_garrafa", 32'(garrafa_aprovada), 32'd1);
    finish_ok("auto1");
    expect_reject();
    auto_run(1'b0);
    measure_discard("auto_rej");
    finish_ok("auto_rej");
    expect_approve();
    auto_run(1'b1);
    finish_ok("auto2");
    check("auto_cnt_sat", 32'(cnt_aprovadas), 32'd3);
    expect_reject();
    auto_run(1'b0);
    measure_discard("auto_rej2");
    finish_ok("auto_rej2");

    // Abort in AGUARDA_DECISAO, then stray pulso_start in IDLE
    modo_auto = 1'b0;
    start_manual();
    cmd_verificar = 1'b0;
    tick();
    tick();
    check("abort_tarefa", 32'(tarefa_concluida), 32'd0);
    check("abort_cnt_ap", 32'(cnt_aprovadas), 32'(m_ap));
    check("abort_cnt_rej", 32'(cnt_reprovadas), 32'(m_rej));
    pulso_start = 1'b1;
    resultado_cq = 1'b1;
    tick();
    pulso_start = 1'b0;
    tick();
    check("idle_pulso_ignored", 32'(garrafa_aprovada), 32'd0);

    // Reset in the middle of a discard
    start_manual();
    decide(1'b0);
    wait_hi(2, 6, "rstmid_desc_on");
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_descarte", 32'(descarte_ativo), 32'd0);
    check("rstmid_cnt_ap", 32'(cnt_aprovadas), 32'd0);
    check("rstmid_cnt_rej", 32'(cnt_reprovadas), 32'd0);
    cmd_verificar = 1'b0;
    m_ap = 0; m_rej = 0; m_rejc = 0;
    tick();
    reset = 1'b0;
    tick();

    // Counters restart from zero after reset
    start_manual();
    expect_approve();
    decide(1'b1);
    finish_ok("post_rst");
    check("post_rst_cnt_ap", 32'(cnt_aprovadas), 32'd1);

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
